fwd_hazard_unit: RTL and testbench

- Parametrised forwarding and hazard unit for the pipelined RISC-V core. Generalises EX-stage operand forwarding to NUM_SRC read ports and NUM_FWD downstream stages.
- Adds sequential hazard control:
  - load-use stall detection;
  - a busy scoreboard for one in-flight multi-cycle op (mul/div) with a latency countdown.
- Sits between ID/EX pipeline registers and the EX operand muxes; drives stall/bubble controls to IF/ID/EX.

---
 rtl/fwd_hazard_unit_if.sv | 48 ++++
 rtl/fwd_hazard_unit.sv | 141 ++++++++++++++
 tb/tb_fwd_hazard_unit.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/fwd_hazard_unit_if.sv
// rtl/fwd_hazard_unit_if.sv - Operand/hazard control bus between pipeline control and fwd_hazard_unit
// Stall_cnt/Fwd_cnt are present only when HAZARD_STATS_EN is defined.
interface fwd_hazard_unit_if #(
  parameter int NUM_SRC = 2,
  parameter int NUM_FWD = 2
);
  localparam int SEL_W = $clog2(NUM_FWD + 1);

  logic [NUM_SRC*5-1:0]     Rs_EX;
  logic [NUM_SRC*5-1:0]     Rs_ID;
  logic [4:0]               Rd_EX;
  logic                     MemRead_EX;
  logic                     McStart_EX;
  logic                     McOp_ID;
  logic [NUM_FWD*5-1:0]     Rd_FWD;
  logic [NUM_FWD-1:0]       RegWrite_FWD;

  logic [NUM_SRC*SEL_W-1:0] Fwd_sel;
  logic                     Stall_ID;
  logic                     Bubble_EX;
  logic                     Mc_busy;
  logic                     Mc_done;
  logic [4:0]               Mc_rd;
`ifdef HAZARD_STATS_EN
  logic [31:0]              Stall_cnt;
  logic [31:0]              Fwd_cnt;
`endif

  modport master (
`ifdef HAZARD_STATS_EN
    input  Stall_cnt, input Fwd_cnt,
`endif
    output Rs_EX, output Rs_ID, output Rd_EX, output MemRead_EX,
    output McStart_EX, output McOp_ID, output Rd_FWD, output RegWrite_FWD,
    input  Fwd_sel, input Stall_ID, input Bubble_EX,
    input  Mc_busy, input Mc_done, input Mc_rd
  );

  modport slave (
`ifdef HAZARD_STATS_EN
    output Stall_cnt, output Fwd_cnt,
`endif
    input  Rs_EX, input Rs_ID, input Rd_EX, input MemRead_EX,
    input  McStart_EX, input McOp_ID, input Rd_FWD, input RegWrite_FWD,
    output Fwd_sel, output Stall_ID, output Bubble_EX,
    output Mc_busy, output Mc_done, output Mc_rd
  );
endinterface

// File: rtl/fwd_hazard_unit.sv
// rtl/fwd_hazard_unit.sv - EX operand forwarding, load-use and multi-cycle busy hazard control
// Optional HAZARD_STATS_EN adds saturating Stall_cnt/Fwd_cnt counters.
module fwd_hazard_unit #(
  parameter int NUM_SRC = 2,
  parameter int NUM_FWD = 2,
  parameter int MC_LAT  = 4,
  localparam int SEL_W  = $clog2(NUM_FWD + 1)
) (
  input  logic             CLK,
  input  logic             RESET,
  fwd_hazard_unit_if.slave bus
);

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } mc_state_t;

  // MC_LAT is limited to 2..15 so the countdown fits in four bits.
  localparam logic [3:0] CNT_INIT = 4'(MC_LAT - 1);

  logic [NUM_SRC*SEL_W-1:0] fwd_sel;
  logic                     luse;
  logic                     mc_haz;
  logic                     stall;

  mc_state_t                state;
  logic [3:0]               cnt;
  logic [4:0]               mc_rd;
  logic                     mc_done;

  // Scan oldest to youngest so the youngest matching stage overwrites older ones.
  always_comb begin
    fwd_sel = '0;
    for (int j = 0; j < NUM_SRC; j++) begin
      for (int i = NUM_FWD - 1; i >= 0; i--) begin
        if (bus.RegWrite_FWD[i] &&
            (bus.Rd_FWD[i*5 +: 5] != 5'd0) &&
            (bus.Rd_FWD[i*5 +: 5] == bus.Rs_EX[j*5 +: 5])) begin
          fwd_sel[j*SEL_W +: SEL_W] = SEL_W'(NUM_FWD - i);
        end
      end
    end
  end

  always_comb begin
    luse = 1'b0;
    if (bus.MemRead_EX && (bus.Rd_EX != 5'd0)) begin
      for (int j = 0; j < NUM_SRC; j++) begin
        if (bus.Rs_ID[j*5 +: 5] == bus.Rd_EX) begin
          luse = 1'b1;
        end
      end
    end
  end

  // A zero Mc_rd still blocks other multi-cycle ops but never creates a data hazard.
  always_comb begin
    mc_haz = 1'b0;
    if (state == BUSY) begin
      if (bus.McOp_ID) begin
        mc_haz = 1'b1;
      end
      if (mc_rd != 5'd0) begin
        for (int j = 0; j < NUM_SRC; j++) begin
          if (bus.Rs_ID[j*5 +: 5] == mc_rd) begin
            mc_haz = 1'b1;
          end
        end
      end
    end
  end

  assign stall = luse || mc_haz;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state   <= IDLE;
      cnt     <= 4'd0;
      mc_rd   <= 5'd0;
      mc_done <= 1'b0;
    end else begin
      mc_done <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.McStart_EX) begin
            state <= BUSY;
            cnt   <= CNT_INIT;
            mc_rd <= bus.Rd_EX;
          end else begin
            // Holds through the Mc_done cycle, cleared on the edge that ends it.
            mc_rd <= 5'd0;
          end
        end
        BUSY: begin
          if (cnt <= 4'd1) begin
            state   <= IDLE;
            cnt     <= 4'd0;
            mc_done <= 1'b1;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        default: begin
          state <= IDLE;
          cnt   <= 4'd0;
        end
      endcase
    end
  end

  assign bus.Fwd_sel   = fwd_sel;
  assign bus.Stall_ID  = stall;
  assign bus.Bubble_EX = stall;
  assign bus.Mc_busy   = (state == BUSY);
  assign bus.Mc_done   = mc_done;
  assign bus.Mc_rd     = mc_rd;

`ifdef HAZARD_STATS_EN
  logic [31:0] stall_cnt;
  logic [31:0] fwd_cnt;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      stall_cnt <= 32'd0;
      fwd_cnt   <= 32'd0;
    end else begin
      if (stall && (stall_cnt != 32'hFFFF_FFFF)) begin
        stall_cnt <= stall_cnt + 32'd1;
      end
      if ((|fwd_sel) && (fwd_cnt != 32'hFFFF_FFFF)) begin
        fwd_cnt <= fwd_cnt + 32'd1;
      end
    end
  end

  assign bus.Stall_cnt = stall_cnt;
  assign bus.Fwd_cnt   = fwd_cnt;
`endif

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// tb/tb_fwd_hazard_unit.sv - Scoreboard bench for fwd_hazard_unit (counter checks when HAZARD_STATS_EN is defined)
module tb_fwd_hazard_unit;

  logic CLK   = 1'b0;
  logic RESET = 1'b1;

  always #5 CLK = ~CLK;

  fwd_hazard_unit_if #(.NUM_SRC(2), .NUM_FWD(2)) bus ();

  fwd_hazard_unit #(
    .NUM_SRC(2),
    .NUM_FWD(2),
    .MC_LAT (4)
  ) dut (
    .CLK  (CLK),
    .RESET(RESET),
    .bus  (bus)
  );

  typedef struct packed {
    logic [3:0]  sel;
    logic        stall;
    logic        busy;
    logic        done;
    logic [4:0]  rd;
    logic [31:0] scnt;
    logic [31:0] fcnt;
  } exp_t;

  exp_t  exp_q[$];
  string name_q[$];

  int n_pass  = 0;
  int n_total = 0;

  logic [31:0] m_scnt = 32'd0;
  logic [31:0] m_fcnt = 32'd0;

  task automatic chk(input string nm, input string fld, input logic [31:0] act, input logic [31:0] req);
    n_total++;
    if (act === req) begin
      n_pass++;
    end else begin
      $display("FAIL %s.%s: got %0h required %0h", nm, fld, act, req);
    end
  endtask

  // ctl = {McOp_ID, McStart_EX, MemRead_EX}; e_flg = {stall, busy, done}
  task automatic step(input string nm, input logic rst,
                      input logic [9:0] rs_ex, input logic [9:0] rs_id, input logic [4:0] rd_ex,
                      input logic [2:0] ctl, input logic [9:0] rd_fwd, input logic [1:0] rw,
                      input logic [3:0] e_sel, input logic [2:0] e_flg, input logic [4:0] e_rd);
    exp_t e;
    @(posedge CLK);
    #1;
    RESET            = rst;
    bus.Rs_EX        = rs_ex;
    bus.Rs_ID        = rs_id;
    bus.Rd_EX        = rd_ex;
    bus.McOp_ID      = ctl[2];
    bus.McStart_EX   = ctl[1];
    bus.MemRead_EX   = ctl[0];
    bus.Rd_FWD       = rd_fwd;
    bus.RegWrite_FWD = rw;
    e.sel   = e_sel;
    e.stall = e_flg[2];
    e.busy  = e_flg[1];
    e.done  = e_flg[0];
    e.rd    = e_rd;
    e.scnt  = m_scnt;
    e.fcnt  = m_fcnt;
    exp_q.push_back(e);
    name_q.push_back(nm);
    // Counters register this cycle's stall/forward activity unless reset wins.
    if (rst) begin
      m_scnt = 32'd0;
      m_fcnt = 32'd0;
    end else begin
      if (e_flg[2]) m_scnt = m_scnt + 32'd1;
      if (e_sel != 4'd0) m_fcnt = m_fcnt + 32'd1;
    end
  endtask

  always @(negedge CLK) begin
    if (exp_q.size() > 0) begin
      exp_t  e;
      string nm;
      e  = exp_q.pop_front();
      nm = name_q.pop_front();
      chk(nm, "fwd_sel",   32'(bus.Fwd_sel),   32'(e.sel));
      chk(nm, "stall_id",  32'(bus.Stall_ID),  32'(e.stall));
      chk(nm, "bubble_ex", 32'(bus.Bubble_EX), 32'(e.stall));
      chk(nm, "mc_busy",   32'(bus.Mc_busy),   32'(e.busy));
      chk(nm, "mc_done",   32'(bus.Mc_done),   32'(e.done));
      chk(nm, "mc_rd",     32'(bus.Mc_rd),     32'(e.rd));
`ifdef HAZARD_STATS_EN
      chk(nm, "stall_cnt", bus.Stall_cnt, e.scnt);
      chk(nm, "fwd_cnt",   bus.Fwd_cnt,   e.fcnt);
`endif
    end
  end

  initial begin
    bus.Rs_EX = '0; bus.Rs_ID = '0; bus.Rd_EX = '0;
    bus.MemRead_EX = 1'b0; bus.McStart_EX = 1'b0; bus.McOp_ID = 1'b0;
    bus.Rd_FWD = '0; bus.RegWrite_FWD = '0;

    //   name          rst  Rs_EX{rs2,rs1}   Rs_ID{rs2,rs1}   Rd_EX  ctl     Rd_FWD{WB,MEM}    RW     sel      flg     rd
    step("reset",      1, {5'd0,5'd0},  {5'd0,5'd0},  5'd0,  3'b000, {5'd0,5'd0},  2'b00, 4'b0000, 3'b000, 5'd0);
    step("fwd_mem_pri",0, {5'd5,5'd5},  {5'd0,5'd0},  5'd0,  3'b000, {5'd5,5'd5},  2'b11, 4'b1010, 3'b000, 5'd0);
    step("fwd_x0",     0, {5'd0,5'd7},  {5'd0,5'd0},  5'd0,  3'b000, {5'd7,5'd0},  2'b11, 4'b0001, 3'b000, 5'd0);
    step("fwd_wb_only",0, {5'd3,5'd3},  {5'd0,5'd0},  5'd0,  3'b000, {5'd3,5'd4},  2'b10, 4'b0101, 3'b000, 5'd0);
    step("fwd_no_we",  0, {5'd3,5'd3},  {5'd0,5'd0},  5'd0,  3'b000, {5'd3,5'd3},  2'b00, 4'b0000, 3'b000, 5'd0);
    step("luse",       0, {5'd0,5'd0},  {5'd3,5'd1},  5'd3,  3'b001, {5'd0,5'd0},  2'b00, 4'b0000, 3'b100, 5'd0);
    step("luse_clear", 0, {5'd0,5'd0},  {5'd3,5'd1},  5'd3,  3'b000, {5'd0,5'd0},  2'b00, 4'b0000, 3'b000, 5'd0);
    step("luse_x0",    0, {5'd0,5'd0},  {5'd0,5'd0},  5'd0,  3'b001, {5'd0,5'd0},  2'b00, 4'b0000, 3'b000, 5'd0);
    step("mc_issue",   0, {5'd0,5'd0},  {5'd0,5'd9},  5'd9,  3'b010, {5'd0,5'd0},  2'b00, 4'b0000, 3'b000, 5'd0);
    step("mc_busy3",   0, {5'd0,5'd0},  {5'd0,5'd9},  5'd0,  3'b000, {5'd0,5'd0},  2'b00, 4'b0000, 3'b110, 5'd9);
    step("mc_busy2",   0, {5'd0,5'd0},  {5'd0,5'd9},  5'd0,  3'b000, {5'd0,5'd0},  2'b00, 4'b0000, 3'b110, 5'd9);
    step("mc_busy1",   0, {5'd0,5'd0},  {5'd0,5'd9},  5'd0,  3'b000, {5'd0,5'd0},  2'b00, 4'b0000, 3'b110, 5'd9);
    step("mc_done",    0, {5'd0,5'd0},  {5'd0,5'd9},  5'd0,  3'b000, {5'd0,5'd0},  2'b00, 4'b0000, 3'b001, 5'd9);
    step("mc_rd_clr",  0, {5'd0,5'd0},  {5'd0,5'd0},  5'd0,  3'b000, {5'd0,5'd0},  2'b00, 4'b0000, 3'b000, 5'd0);
    step("mc_issue_x0",0, {5'd0,5'd0},  {5'd0,5'd0},  5'd0,  3'b010, {5'd0,5'd0},  2'b00, 4'b0000, 3'b000, 5'd0);
    step("combo_stall",0, {5'd0,5'd0},  {5'd4,5'd0},  5'd4,  3'b101, {5'd0,5'd0},  2'b00, 4'b0000, 3'b110, 5'd0);
    step("mcop_rst",   1, {5'd0,5'd0},  {5'd0,5'd0},  5'd0,  3'b100, {5'd0,5'd0},  2'b00, 4'b0000, 3'b110, 5'd0);
    step("post_rst",   0, {5'd0,5'd0},  {5'd0,5'd0},  5'd0,  3'b100, {5'd0,5'd0},  2'b00, 4'b0000, 3'b000, 5'd0);
    step("no_done",    0, {5'd0,5'd0},  {5'd0,5'd0},  5'd0,  3'b100, {5'd0,5'd0},  2'b00, 4'b0000, 3'b000, 5'd0);
    step("mc_issue12", 0, {5'd0,5'd0},  {5'd0,5'd0},  5'd12, 3'b010, {5'd0,5'd0},  2'b00, 4'b0000, 3'b000, 5'd0);
    step("mc_ignore",  0, {5'd0,5'd0},  {5'd0,5'd0},  5'd13, 3'b010, {5'd0,5'd0},  2'b00, 4'b0000, 3'b010, 5'd12);
    step("mc12_b2",    0, {5'd0,5'd0},  {5'd0,5'd0},  5'd0,  3'b000, {5'd0,5'd0},  2'b00, 4'b0000, 3'b010, 5'd12);
    step("mc12_b1",    0, {5'd0,5'd0},  {5'd0,5'd0},  5'd0,  3'b000, {5'd0,5'd0},  2'b00, 4'b0000, 3'b010, 5'd12);
    step("mc12_done",  0, {5'd0,5'd0},  {5'd0,5'd0},  5'd0,  3'b000, {5'd0,5'd0},  2'b00, 4'b0000, 3'b001, 5'd12);
    step("mc12_clr",   0, {5'd0,5'd0},  {5'd0,5'd0},  5'd0,  3'b000, {5'd0,5'd0},  2'b00, 4'b0000, 3'b000, 5'd0);
    // Counter scenario: three stall cycles then two forwarding cycles after a clean reset.
    step("st_reset",   1, {5'd0,5'd0},  {5'd0,5'd0},  5'd0,  3'b000, {5'd0,5'd0},  2'b00, 4'b0000, 3'b000, 5'd0);
    step("st_stall1",  0, {5'd0,5'd0},  {5'd3,5'd0},  5'd3,  3'b001, {5'd0,5'd0},  2'b00, 4'b0000, 3'b100, 5'd0);
    step("st_stall2",  0, {5'd0,5'd0},  {5'd3,5'd0},  5'd3,  3'b001, {5'd0,5'd0},  2'b00, 4'b0000, 3'b100, 5'd0);
    step("st_stall3",  0, {5'd0,5'd0},  {5'd3,5'd0},  5'd3,  3'b001, {5'd0,5'd0},  2'b00, 4'b0000, 3'b100, 5'd0);
    step("st_fwd1",    0, {5'd0,5'd5},  {5'd0,5'd0},  5'd0,  3'b000, {5'd0,5'd5},  2'b01, 4'b0010, 3'b000, 5'd0);
    step("st_fwd2",    0, {5'd0,5'd5},  {5'd0,5'd0},  5'd0,  3'b000, {5'd0,5'd5},  2'b01, 4'b0010, 3'b000, 5'd0);
    step("st_hold",    0, {5'd0,5'd0},  {5'd0,5'd0},  5'd0,  3'b000, {5'd0,5'd0},  2'b00, 4'b0000, 3'b000, 5'd0);
    step("st_rst",     1, {5'd0,5'd0},  {5'd0,5'd0},  5'd0,  3'b000, {5'd0,5'd0},  2'b00, 4'b0000, 3'b000, 5'd0);
    step("st_cleared", 0, {5'd0,5'd0},  {5'd0,5'd0},  5'd0,  3'b000, {5'd0,5'd0},  2'b00, 4'b0000, 3'b000, 5'd0);

    repeat (2) @(negedge CLK);
    for (int k = 0; k < 10 && exp_q.size() != 0; k++) @(negedge CLK);
    #1;
    if (exp_q.size() != 0) begin
      n_total++;
      $display("FAIL drain: %0d entries left, required 0", exp_q.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
